// File: rtl/dac_pair_spi_tx.sv
// Serializes one captured 16-bit sample pair as two 24-bit SPI frames (command byte + data)
// to a dual-channel DAC. SPI mode 0, MSB first, one pair per in_ready window.
module dac_pair_spi_tx #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned FRAME_GAP = 2,
    parameter logic [7:0]  CMD_A     = 8'h30,
    parameter logic [7:0]  CMD_B     = 8'h31,
    parameter bit          TWOS_COMP = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] s1,
    input  logic [15:0] s2,
    output logic        in_ready,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0]  HP_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0]  GAP_LAST  = 8'(FRAME_GAP - 1);
    localparam logic [15:0] DATA_FLIP = TWOS_COMP ? 16'h8000 : 16'h0000;

    typedef enum logic [2:0] {
        StIdle,
        StShiftA,
        StGapA,
        StShiftB,
        StGapB
    } state_e;

    state_e      r_state;
    state_e      w_state_d;

    logic [7:0]  r_hp_cnt;
    logic [4:0]  r_bit_cnt;
    logic [7:0]  r_gap_cnt;
    logic        r_sclk_lvl;
    logic [23:0] r_frame_a;
    logic [23:0] r_frame_b;

    logic        w_accept;
    logic        w_shifting;
    logic        w_gapping;
    logic        w_hp_last;
    logic        w_frame_last;
    logic        w_gap_last;

    assign w_accept     = (r_state == StIdle) && in_valid;
    assign w_shifting   = (r_state == StShiftA) || (r_state == StShiftB);
    assign w_gapping    = (r_state == StGapA) || (r_state == StGapB);
    assign w_hp_last    = (r_hp_cnt == HP_LAST);
    // Frame ends on the falling-edge slot that follows the 24th rising edge.
    assign w_frame_last = w_shifting && w_hp_last && r_sclk_lvl && (r_bit_cnt == 5'd0);
    assign w_gap_last   = (r_gap_cnt == GAP_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:   if (in_valid)     w_state_d = StShiftA;
            StShiftA: if (w_frame_last) w_state_d = StGapA;
            StGapA:   if (w_gap_last)   w_state_d = StShiftB;
            StShiftB: if (w_frame_last) w_state_d = StGapB;
            StGapB:   if (w_gap_last)   w_state_d = StIdle;
            default:                    w_state_d = StIdle;
        endcase
    end

    // Half-period, bit and gap counters; all restart on every state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hp_cnt   <= 8'd0;
            r_bit_cnt  <= 5'd23;
            r_gap_cnt  <= 8'd0;
            r_sclk_lvl <= 1'b0;
        end else if (w_state_d != r_state) begin
            r_hp_cnt   <= 8'd0;
            r_bit_cnt  <= 5'd23;
            r_gap_cnt  <= 8'd0;
            r_sclk_lvl <= 1'b0;
        end else if (w_shifting) begin
            if (w_hp_last) begin
                r_hp_cnt   <= 8'd0;
                r_sclk_lvl <= ~r_sclk_lvl;
                if (r_sclk_lvl) begin
                    r_bit_cnt <= r_bit_cnt - 5'd1;
                end
            end else begin
                r_hp_cnt <= r_hp_cnt + 8'd1;
            end
        end else if (w_gapping) begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
        end
    end

    // Sample capture; inputs are not looked at again until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_a <= 24'd0;
            r_frame_b <= 24'd0;
        end else if (w_accept) begin
            r_frame_a <= {CMD_A, s1 ^ DATA_FLIP};
            r_frame_b <= {CMD_B, s2 ^ DATA_FLIP};
        end
    end

    // Output logic
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        cs_n     = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        done     = 1'b0;
        case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            StShiftA: begin
                cs_n = 1'b0;
                sclk = r_sclk_lvl;
                mosi = r_frame_a[r_bit_cnt];
            end
            StShiftB: begin
                cs_n = 1'b0;
                sclk = r_sclk_lvl;
                mosi = r_frame_b[r_bit_cnt];
            end
            StGapB: begin
                done = w_gap_last;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_dac_pair_spi_tx.sv
// Bench for dac_pair_spi_tx: three instances (defaults, two's complement, fastest timing),
// a per-instance SPI decoder popping an expected-frame scoreboard, and timing checks.
module tb_dac_pair_spi_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  vld;
    logic [2:0]  rdy;
    logic [2:0]  sclk;
    logic [2:0]  cs_n;
    logic [2:0]  mosi;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [15:0] s1v [3];
    logic [15:0] s2v [3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    logic [23:0] exp_q [$];

    function automatic int cd_of(input int idx);
        return (idx == 2) ? 1 : 4;
    endfunction

    function automatic int fg_of(input int idx);
        return (idx == 2) ? 1 : 2;
    endfunction

    function automatic int lat_of(input int idx);
        return 96 * cd_of(idx) + 2 * fg_of(idx);
    endfunction

    function automatic logic [23:0] frame_of(input int idx, input logic [7:0] cmd,
                                             input logic [15:0] s);
        return {cmd, (idx == 1) ? (s ^ 16'h8000) : s};
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int CD = (g == 2) ? 1 : 4;
            localparam int FG = (g == 2) ? 1 : 2;

            dac_pair_spi_tx #(
                .CLK_DIV   (CD),
                .FRAME_GAP (FG),
                .CMD_A     (8'h30),
                .CMD_B     (8'h31),
                .TWOS_COMP (g == 1)
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .in_valid (vld[g]),
                .s1       (s1v[g]),
                .s2       (s2v[g]),
                .in_ready (rdy[g]),
                .sclk     (sclk[g]),
                .cs_n     (cs_n[g]),
                .mosi     (mosi[g]),
                .busy     (busy[g]),
                .done     (done[g])
            );

            // SPI decoder, sampled on the falling clk edge away from all DUT updates.
            initial begin
                logic        p_sclk;
                logic        p_cs;
                logic        p_mosi;
                logic        inf;
                logic [23:0] sh;
                logic [23:0] e;
                int          nb;
                int          low_cnt;
                int          hi_cnt;
                int          fcnt;
                p_sclk = 1'b0; p_cs = 1'b1; p_mosi = 1'b0; inf = 1'b0;
                sh = '0; nb = 0; low_cnt = 0; hi_cnt = 0; fcnt = 0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        inf = 1'b0; nb = 0; fcnt = 0; hi_cnt = 0;
                        p_cs = 1'b1; p_sclk = 1'b0; p_mosi = 1'b0;
                    end else begin
                        if (cs_n[g] && sclk[g]) begin
                            n_err++;
                            $display("FAIL dut%0d sclk_idle: sclk=%b while cs_n=1 (want 0)", g,
                                     sclk[g]);
                        end
                        if (!cs_n[g] && p_cs) begin
                            if (fcnt % 2 == 1) begin
                                n_vec++;
                                if (hi_cnt != FG) begin
                                    n_err++;
                                    $display("FAIL dut%0d frame_gap: got %0d want %0d", g, hi_cnt,
                                             FG);
                                end
                            end
                            inf = 1'b1; nb = 0; low_cnt = 0; sh = '0;
                        end
                        if (!cs_n[g]) begin
                            low_cnt++;
                            if (sclk[g] && !p_sclk) begin
                                if (mosi[g] !== p_mosi) begin
                                    n_err++;
                                    $display("FAIL dut%0d mosi_stable: got %b want %b at rise %0d",
                                             g, mosi[g], p_mosi, nb);
                                end
                                sh = {sh[22:0], mosi[g]};
                                nb++;
                            end
                        end
                        if (cs_n[g] && !p_cs && inf) begin
                            n_vec += 3;
                            if (exp_q.size() == 0) begin
                                n_err++;
                                $display("FAIL dut%0d frame_unexpected: got %h want none", g, sh);
                            end else begin
                                e = exp_q.pop_front();
                                if (sh !== e) begin
                                    n_err++;
                                    $display("FAIL dut%0d frame_data: got %h want %h", g, sh, e);
                                end
                            end
                            if (nb != 24) begin
                                n_err++;
                                $display("FAIL dut%0d frame_rises: got %0d want 24", g, nb);
                            end
                            if (low_cnt != 48 * CD || mosi[g] !== 1'b0 || sclk[g] !== 1'b0) begin
                                n_err++;
                                $display("FAIL dut%0d frame_end: cs_low=%0d mosi=%b want %0d/0", g,
                                         low_cnt, mosi[g], 48 * CD);
                            end
                            inf = 1'b0; fcnt++; hi_cnt = 0;
                        end
                        if (cs_n[g]) hi_cnt++;
                        p_cs = cs_n[g]; p_sclk = sclk[g]; p_mosi = mosi[g];
                    end
                end
            end
        end
    endgenerate

    // Accepts one pair, queues its two frames and checks the timing back to idle.
    task automatic run_pair(input int idx, input string name, input logic [15:0] a,
                            input logic [15:0] b, input logic [23:0] ea, input logic [23:0] eb,
                            input bit hold, output int acc);
        int n = 0;
        int lat_rdy = -1;
        int lat_done = -1;
        int ndone = 0;
        int busy_bad = 0;
        s1v[idx] = a; s2v[idx] = b; vld[idx] = 1'b1;
        while (!rdy[idx] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        n_vec++;
        if (!rdy[idx]) begin
            n_err++;
            vld[idx] = 1'b0;
            $display("FAIL %s accept: in_ready=%b want 1 within 2000 cycles", name, rdy[idx]);
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        exp_q.push_back(ea);
        exp_q.push_back(eb);
        if (hold) begin
            s1v[idx] = 16'($urandom);
            s2v[idx] = 16'($urandom);
        end else begin
            vld[idx] = 1'b0;
        end
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done[idx]) begin
                ndone++;
                lat_done = cyc - acc;
            end
            if (busy[idx] === rdy[idx]) busy_bad++;
            if (rdy[idx]) begin
                lat_rdy = cyc - acc;
                break;
            end
        end
        n_vec += 4;
        if (lat_rdy != lat_of(idx)) begin
            n_err++;
            $display("FAIL %s ready_latency: got %0d want %0d", name, lat_rdy, lat_of(idx));
        end
        if (lat_done != lat_of(idx) - 1) begin
            n_err++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, lat_done + 1, lat_of(idx));
        end
        if (ndone != 1) begin
            n_err++;
            $display("FAIL %s done_count: got %0d want 1", name, ndone);
        end
        if (busy_bad != 0) begin
            n_err++;
            $display("FAIL %s busy: %0d cycles with busy==in_ready, want 0", name, busy_bad);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s frames_left: got %0d want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({rdy[i], sclk[i], cs_n[i], mosi[i], busy[i], done[i]} !== 6'b101000) begin
                n_err++;
                $display("FAIL reset_hold dut%0d: got %b want 101000", i,
                         {rdy[i], sclk[i], cs_n[i], mosi[i], busy[i], done[i]});
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({rdy[i], sclk[i], cs_n[i], mosi[i], busy[i], done[i]} !== 6'b101000) begin
                n_err++;
                $display("FAIL reset_idle dut%0d: got %b want 101000", i,
                         {rdy[i], sclk[i], cs_n[i], mosi[i], busy[i], done[i]});
            end
        end
    endtask

    task automatic test_basic();
        int acc;
        run_pair(0, "basic0", 16'h8000, 16'h8147, 24'h308000, 24'h318147, 1'b0, acc);
        run_pair(0, "basic1", 16'hFFFF, 16'h0001, 24'h30FFFF, 24'h310001, 1'b0, acc);
        run_pair(0, "basic2", 16'h5A5A, 16'hA5A5, frame_of(0, 8'h30, 16'h5A5A),
                 frame_of(0, 8'h31, 16'hA5A5), 1'b0, acc);
    endtask

    task automatic test_twos_comp();
        int acc;
        run_pair(1, "tc0", 16'h7EB8, 16'h8000, 24'h30FEB8, 24'h310000, 1'b0, acc);
        run_pair(1, "tc1", 16'h0000, 16'hFFFF, 24'h308000, 24'h317FFF, 1'b0, acc);
    endtask

    task automatic test_back_to_back();
        int acc [3];
        logic [15:0] pa [3] = '{16'h1111, 16'hBEEF, 16'h0F0F};
        logic [15:0] pb [3] = '{16'h2222, 16'hCAFE, 16'hF0F0};
        for (int k = 0; k < 3; k++) begin
            run_pair(0, "b2b", pa[k], pb[k], frame_of(0, 8'h30, pa[k]),
                     frame_of(0, 8'h31, pb[k]), 1'b1, acc[k]);
        end
        vld[0] = 1'b0;
        // Next accept lands on the first IDLE cycle after in_ready returns.
        for (int k = 1; k < 3; k++) begin
            n_vec++;
            if (acc[k] - acc[k - 1] != lat_of(0) + 1) begin
                n_err++;
                $display("FAIL b2b_spacing %0d: got %0d want %0d", k, acc[k] - acc[k - 1],
                         lat_of(0) + 1);
            end
        end
    endtask

    task automatic test_midframe_reset();
        int acc;
        int n = 0;
        int ndone = 0;
        s1v[0] = 16'h1357; s2v[0] = 16'h2468; vld[0] = 1'b1;
        while (!rdy[0] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        vld[0] = 1'b0;
        exp_q.push_back(24'h301357);
        exp_q.push_back(24'h312468);
        // Frame B starts after 48*CLK_DIV + FRAME_GAP; rise 13 (bit 10) is at offset 27*CLK_DIV.
        while (cyc < acc + 194 + 108) begin
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (cs_n[0] !== 1'b0 || sclk[0] !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre: cs_n=%b sclk=%b want 0/1", cs_n[0], sclk[0]);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({cs_n[0], sclk[0], rdy[0], busy[0]} !== 4'b1010) begin
            n_err++;
            $display("FAIL rst_immediate: cs_n/sclk/ready/busy=%b want 1010",
                     {cs_n[0], sclk[0], rdy[0], busy[0]});
        end
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done[0]) ndone++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done[0]) ndone++;
        end
        n_vec++;
        if (ndone != 0 || rdy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL rst_after: done pulses=%0d ready=%b want 0/1", ndone, rdy[0]);
        end
        run_pair(0, "rst_next", 16'h4321, 16'h8765, 24'h304321, 24'h318765, 1'b0, acc);
    endtask

    task automatic test_fast();
        int acc;
        run_pair(2, "fast0", 16'hC3A5, 16'h0F0F, 24'h30C3A5, 24'h310F0F, 1'b0, acc);
        run_pair(2, "fast1", 16'h0001, 16'h8000, 24'h300001, 24'h318000, 1'b0, acc);
    endtask

    initial begin
        rst = 1'b1;
        vld = '0;
        for (int i = 0; i < 3; i++) begin
            s1v[i] = '0;
            s2v[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_twos_comp();
        test_back_to_back();
        test_midframe_reset();
        test_fast();
        repeat (5) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL final_queue: got %0d frames pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
